// File: rtl/rice_core_bus_arbiter.sv
// rice_core_bus_arbiter
//
// Lets the instruction-fetch port and the load/store data port share one
// memory bus. Only one requester is selected at a time. That selection is
// held from the cycle the bus first stalls it until the bus accepts it.
// Every accepted transaction records its requester ID (0 = inst, 1 = data)
// in an in-order FIFO. Each bus response goes back to the requester at the
// FIFO head.
//
// Handshake: a transfer happens on a rising i_clk edge where valid and ready
// are both high. The sender holds valid and every payload field stable until
// that edge. Ready may depend combinationally on valid.
//
// Optional feature macro: RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
//   defined   : round-robin between the two ports. A last_grant register is
//               reset to data, so inst wins the first contested grant.
//   undefined : fixed priority. The data port wins over the instruction port.
//
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_inst_request_valid / o_inst_request_ready / i_inst_address
//                                     fetch request channel
//   o_inst_response_valid / i_inst_response_ready / o_inst_read_data /
//   o_inst_error                      fetch response channel
//   i_data_request_valid / o_data_request_ready / i_data_address /
//   i_data_write / i_data_write_data / i_data_strobe
//                                     load/store request channel
//   o_data_response_valid / i_data_response_ready / o_data_read_data /
//   o_data_error                      load/store response channel
//   o_bus_request_valid / i_bus_request_ready / o_bus_address / o_bus_write /
//   o_bus_write_data / o_bus_strobe   shared bus request channel
//   i_bus_response_valid / o_bus_response_ready / i_bus_read_data /
//   i_bus_error                       shared bus response channel
//   o_lock_state, o_outstanding_count debug view of lock FSM and counter
module rice_core_bus_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int STROBE_WIDTH   = DATA_WIDTH / 8,
  localparam int COUNT_WIDTH    = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,

  input  logic                     i_inst_request_valid,
  output logic                     o_inst_request_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_inst_address,
  output logic                     o_inst_response_valid,
  input  logic                     i_inst_response_ready,
  output logic [DATA_WIDTH-1:0]    o_inst_read_data,
  output logic                     o_inst_error,

  input  logic                     i_data_request_valid,
  output logic                     o_data_request_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_data_address,
  input  logic                     i_data_write,
  input  logic [DATA_WIDTH-1:0]    i_data_write_data,
  input  logic [STROBE_WIDTH-1:0]  i_data_strobe,
  output logic                     o_data_response_valid,
  input  logic                     i_data_response_ready,
  output logic [DATA_WIDTH-1:0]    o_data_read_data,
  output logic                     o_data_error,

  output logic                     o_bus_request_valid,
  input  logic                     i_bus_request_ready,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic                     o_bus_write,
  output logic [DATA_WIDTH-1:0]    o_bus_write_data,
  output logic [STROBE_WIDTH-1:0]  o_bus_strobe,
  input  logic                     i_bus_response_valid,
  output logic                     o_bus_response_ready,
  input  logic [DATA_WIDTH-1:0]    i_bus_read_data,
  input  logic                     i_bus_error,

  output logic [1:0]               o_lock_state,
  output logic [COUNT_WIDTH-1:0]   o_outstanding_count
);

  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_WIDTH-1:0]   LAST_PTR  = PTR_WIDTH'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } lock_state_t;

  lock_state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]       count_q;
  logic [MAX_OUTSTANDING-1:0]   id_fifo_q;
  logic [PTR_WIDTH-1:0]         wr_ptr_q, rd_ptr_q;

  logic sel_inst, sel_data, sel_valid;
  logic can_issue, bus_accept;
  logic fifo_empty, head_id, pop;

`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q;  // 1 = data was granted last
`endif

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + PTR_WIDTH'(1);
  endfunction

  // The registered count gates issue. A response popped in the same cycle
  // does not free a slot until the next cycle.
  assign can_issue = (count_q < MAX_COUNT);

  // Selection. A lock state forces its requester. A stalled requester must
  // hold valid, so the lock never points at an idle port.
  always_comb begin
    sel_inst = 1'b0;
    sel_data = 1'b0;
    case (state_q)
      LOCK_INST: sel_inst = 1'b1;
      LOCK_DATA: sel_data = 1'b1;
      default: begin
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
        if (i_inst_request_valid && i_data_request_valid) begin
          if (last_grant_q) sel_inst = 1'b1;
          else              sel_data = 1'b1;
        end else begin
          sel_inst = i_inst_request_valid;
          sel_data = i_data_request_valid;
        end
`else
        if (i_data_request_valid)      sel_data = 1'b1;
        else if (i_inst_request_valid) sel_inst = 1'b1;
`endif
      end
    endcase
  end

  assign sel_valid = (sel_inst && i_inst_request_valid) ||
                     (sel_data && i_data_request_valid);

  // Request forwarding is zero-latency. The muxed fields are zero when
  // nothing is selected.
  always_comb begin
    o_bus_address    = '0;
    o_bus_write      = 1'b0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    if (sel_data) begin
      o_bus_address    = i_data_address;
      o_bus_write      = i_data_write;
      o_bus_write_data = i_data_write_data;
      o_bus_strobe     = i_data_strobe;
    end else if (sel_inst) begin
      o_bus_address    = i_inst_address;
    end
  end

  assign o_bus_request_valid  = sel_valid && can_issue;
  assign o_inst_request_ready = sel_inst && i_bus_request_ready && can_issue;
  assign o_data_request_ready = sel_data && i_bus_request_ready && can_issue;
  assign bus_accept           = o_bus_request_valid && i_bus_request_ready;

  // Lock FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: begin
        if (sel_valid && !i_bus_request_ready)
          state_d = sel_data ? LOCK_DATA : LOCK_INST;
      end
      LOCK_INST, LOCK_DATA: begin
        if (bus_accept) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Response routing from the FIFO head. Data and error go to both ports;
  // only the head's valid is raised.
  assign fifo_empty = (count_q == '0);
  assign head_id    = id_fifo_q[rd_ptr_q];

  assign o_inst_response_valid = i_bus_response_valid && !fifo_empty && !head_id;
  assign o_data_response_valid = i_bus_response_valid && !fifo_empty &&  head_id;
  assign o_bus_response_ready  = !fifo_empty &&
                                 (head_id ? i_data_response_ready : i_inst_response_ready);
  assign o_inst_read_data      = i_bus_read_data;
  assign o_data_read_data      = i_bus_read_data;
  assign o_inst_error          = i_bus_error;
  assign o_data_error          = i_bus_error;
  assign pop                   = i_bus_response_valid && o_bus_response_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= UNLOCKED;
      count_q   <= '0;
      id_fifo_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (bus_accept) begin
        id_fifo_q[wr_ptr_q] <= sel_data;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({bus_accept, pop})
        2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
        2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        last_grant_q <= 1'b1;
    else if (bus_accept) last_grant_q <= sel_data;
  end
`endif

  assign o_lock_state        = state_q;
  assign o_outstanding_count = count_q;

endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
// Directed testbench for rice_core_bus_arbiter with default parameters.
// Expected values are hand-computed. Arbitration expectations follow the
// build macro RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN.
module tb_rice_core_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_inst_request_valid, o_inst_request_ready;
  logic [31:0] i_inst_address;
  logic        o_inst_response_valid, i_inst_response_ready;
  logic [31:0] o_inst_read_data;
  logic        o_inst_error;
  logic        i_data_request_valid, o_data_request_ready;
  logic [31:0] i_data_address;
  logic        i_data_write;
  logic [31:0] i_data_write_data;
  logic [3:0]  i_data_strobe;
  logic        o_data_response_valid, i_data_response_ready;
  logic [31:0] o_data_read_data;
  logic        o_data_error;
  logic        o_bus_request_valid, i_bus_request_ready;
  logic [31:0] o_bus_address;
  logic        o_bus_write;
  logic [31:0] o_bus_write_data;
  logic [3:0]  o_bus_strobe;
  logic        i_bus_response_valid, o_bus_response_ready;
  logic [31:0] i_bus_read_data;
  logic        i_bus_error;
  logic [1:0]  o_lock_state;
  logic [1:0]  o_outstanding_count;

  int total = 0;
  int bad   = 0;

  rice_core_bus_arbiter dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_inst_request_valid  (i_inst_request_valid),
    .o_inst_request_ready  (o_inst_request_ready),
    .i_inst_address        (i_inst_address),
    .o_inst_response_valid (o_inst_response_valid),
    .i_inst_response_ready (i_inst_response_ready),
    .o_inst_read_data      (o_inst_read_data),
    .o_inst_error          (o_inst_error),
    .i_data_request_valid  (i_data_request_valid),
    .o_data_request_ready  (o_data_request_ready),
    .i_data_address        (i_data_address),
    .i_data_write          (i_data_write),
    .i_data_write_data     (i_data_write_data),
    .i_data_strobe         (i_data_strobe),
    .o_data_response_valid (o_data_response_valid),
    .i_data_response_ready (i_data_response_ready),
    .o_data_read_data      (o_data_read_data),
    .o_data_error          (o_data_error),
    .o_bus_request_valid   (o_bus_request_valid),
    .i_bus_request_ready   (i_bus_request_ready),
    .o_bus_address         (o_bus_address),
    .o_bus_write           (o_bus_write),
    .o_bus_write_data      (o_bus_write_data),
    .o_bus_strobe          (o_bus_strobe),
    .i_bus_response_valid  (i_bus_response_valid),
    .o_bus_response_ready  (o_bus_response_ready),
    .i_bus_read_data       (i_bus_read_data),
    .i_bus_error           (i_bus_error),
    .o_lock_state          (o_lock_state),
    .o_outstanding_count   (o_outstanding_count)
  );

  // clock
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_inst_request_valid  = 1'b0;
    i_inst_address        = '0;
    i_inst_response_ready = 1'b0;
    i_data_request_valid  = 1'b0;
    i_data_address        = '0;
    i_data_write          = 1'b0;
    i_data_write_data     = '0;
    i_data_strobe         = '0;
    i_data_response_ready = 1'b0;
    i_bus_request_ready   = 1'b0;
    i_bus_response_valid  = 1'b0;
    i_bus_read_data       = '0;
    i_bus_error           = 1'b0;
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #3;
    i_rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic exp_data;
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;

    // reset state
    check("rst_bus_valid",  o_bus_request_valid,   0);
    check("rst_inst_ready", o_inst_request_ready,  0);
    check("rst_data_ready", o_data_request_ready,  0);
    check("rst_inst_rv",    o_inst_response_valid, 0);
    check("rst_data_rv",    o_data_response_valid, 0);
    check("rst_bus_rr",     o_bus_response_ready,  0);
    check("rst_bus_addr",   o_bus_address,         0);
    check("rst_count",      o_outstanding_count,   0);
    check("rst_state",      o_lock_state,          0);
    cycle();

    // inst only, response one cycle later
    i_inst_request_valid = 1'b1;
    i_inst_address       = 32'h0000_0100;
    i_bus_request_ready  = 1'b1;
    #1;
    check("t1_bus_valid",  o_bus_request_valid,  1);
    check("t1_bus_addr",   o_bus_address,        32'h100);
    check("t1_bus_write",  o_bus_write,          0);
    check("t1_inst_ready", o_inst_request_ready, 1);
    check("t1_data_ready", o_data_request_ready, 0);
    cycle();
    check("t1_count1", o_outstanding_count, 1);
    i_inst_request_valid  = 1'b0;
    i_bus_response_valid  = 1'b1;
    i_bus_read_data       = 32'h0000_0013;
    i_inst_response_ready = 1'b1;
    #1;
    check("t1_inst_rv",   o_inst_response_valid, 1);
    check("t1_inst_rd",   o_inst_read_data,      32'h13);
    check("t1_data_rv",   o_data_response_valid, 0);
    check("t1_bus_rr",    o_bus_response_ready,  1);
    cycle();
    i_bus_response_valid = 1'b0;
    check("t1_count0", o_outstanding_count, 0);

    // both valid for 3 cycles, responses keep the count below the limit
    idle_inputs();
    pulse_reset();
    cycle();
    i_inst_request_valid  = 1'b1;
    i_inst_address        = 32'h0000_1000;
    i_data_request_valid  = 1'b1;
    i_data_address        = 32'h0000_2000;
    i_data_write          = 1'b1;
    i_data_write_data     = 32'hCAFE_F00D;
    i_data_strobe         = 4'hF;
    i_bus_request_ready   = 1'b1;
    i_inst_response_ready = 1'b1;
    i_data_response_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
      exp_data = (i % 2 == 1);
`else
      exp_data = 1'b1;
`endif
      i_bus_response_valid = (i > 0);
      #1;
      check("t2_data_ready", o_data_request_ready, exp_data);
      check("t2_inst_ready", o_inst_request_ready, !exp_data);
      check("t2_bus_addr",   o_bus_address, exp_data ? 32'h2000 : 32'h1000);
      check("t2_bus_write",  o_bus_write,   exp_data);
      cycle();
    end
    check("t2_count1", o_outstanding_count, 1);
    i_inst_request_valid = 1'b0;
    i_data_request_valid = 1'b0;
    i_bus_response_valid = 1'b1;
    #1;
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
    check("t2_drain_data_rv", o_data_response_valid, 0);
`else
    check("t2_drain_data_rv", o_data_response_valid, 1);
`endif
    cycle();
    i_bus_response_valid = 1'b0;
    check("t2_count0", o_outstanding_count, 0);

    // inst locked while bus stalls and data arrives
    idle_inputs();
    i_inst_request_valid = 1'b1;
    i_inst_address       = 32'h0000_0200;
    #1;
    check("t3_bus_valid_c1", o_bus_request_valid, 1);
    check("t3_inst_ready_c1", o_inst_request_ready, 0);
    cycle();
    check("t3_state_lock", o_lock_state, 1);
    i_data_request_valid = 1'b1;
    i_data_address       = 32'h0000_0300;
    #1;
    check("t3_addr_c2", o_bus_address, 32'h200);
    check("t3_data_ready_c2", o_data_request_ready, 0);
    cycle();
    check("t3_state_lock_c3", o_lock_state, 1);
    i_bus_request_ready = 1'b1;
    #1;
    check("t3_inst_ready_c3", o_inst_request_ready, 1);
    check("t3_data_ready_c3", o_data_request_ready, 0);
    check("t3_addr_c3", o_bus_address, 32'h200);
    cycle();
    check("t3_state_unlock", o_lock_state, 0);
    i_inst_request_valid = 1'b0;
    #1;
    check("t3_data_ready_c4", o_data_request_ready, 1);
    check("t3_addr_c4", o_bus_address, 32'h300);
    cycle();
    check("t3_count2", o_outstanding_count, 2);
    i_data_request_valid  = 1'b0;
    i_bus_response_valid  = 1'b1;
    i_inst_response_ready = 1'b1;
    i_data_response_ready = 1'b1;
    #1;
    check("t3_resp1_inst", o_inst_response_valid, 1);
    check("t3_resp1_data", o_data_response_valid, 0);
    cycle();
    check("t3_resp2_inst", o_inst_response_valid, 0);
    check("t3_resp2_data", o_data_response_valid, 1);
    cycle();
    i_bus_response_valid = 1'b0;
    check("t3_count0", o_outstanding_count, 0);

    // outstanding limit and in-order routing with stall
    idle_inputs();
    i_bus_request_ready  = 1'b1;
    i_inst_request_valid = 1'b1;
    i_inst_address       = 32'h0000_0400;
    cycle();
    i_inst_request_valid = 1'b0;
    i_data_request_valid = 1'b1;
    i_data_address       = 32'h0000_0500;
    cycle();
    check("t4_count2", o_outstanding_count, 2);
    i_data_request_valid  = 1'b0;
    i_inst_request_valid  = 1'b1;
    i_inst_address        = 32'h0000_0600;
    i_bus_response_valid  = 1'b1;
    i_bus_read_data       = 32'h0000_AAAA;
    i_data_response_ready = 1'b1;
    i_inst_response_ready = 1'b0;
    #1;
    check("t4_blocked_valid", o_bus_request_valid,   0);
    check("t4_blocked_ready", o_inst_request_ready,  0);
    check("t4_stall_rr",      o_bus_response_ready,  0);
    check("t4_head_inst_rv",  o_inst_response_valid, 1);
    check("t4_head_data_rv",  o_data_response_valid, 0);
    cycle();
    check("t4_count_stall", o_outstanding_count, 2);
    i_inst_response_ready = 1'b1;
    #1;
    check("t4_rr_inst",      o_bus_response_ready, 1);
    check("t4_still_block",  o_bus_request_valid,  0);
    check("t4_inst_rd",      o_inst_read_data,     32'hAAAA);
    cycle();
    check("t4_count_pop", o_outstanding_count, 1);
    i_bus_read_data = 32'h0000_BBBB;
    #1;
    check("t4_unblocked", o_bus_request_valid,   1);
    check("t4_data_rv",   o_data_response_valid, 1);
    check("t4_inst_rv",   o_inst_response_valid, 0);
    check("t4_data_rd",   o_data_read_data,      32'hBBBB);
    cycle();
    check("t4_count_pushpop", o_outstanding_count, 1);
    i_bus_response_valid = 1'b0;
    cycle();
    check("t4_count_full", o_outstanding_count, 2);

    // reset with two outstanding, then a stray response
    idle_inputs();
    i_rst_n = 1'b0;
    #1;
    check("t5_async_count", o_outstanding_count, 0);
    #2;
    i_rst_n = 1'b1;
    #1;
    i_bus_response_valid  = 1'b1;
    i_bus_read_data       = 32'hDEAD_BEEF;
    i_inst_response_ready = 1'b1;
    i_data_response_ready = 1'b1;
    #1;
    check("t5_inst_rv", o_inst_response_valid, 0);
    check("t5_data_rv", o_data_response_valid, 0);
    check("t5_bus_rr",  o_bus_response_ready,  0);
    cycle();
    check("t5_count", o_outstanding_count, 0);
    check("t5_inst_rv2", o_inst_response_valid, 0);
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rice_core_bus_arbiter.md
Name: rice_core_bus_arbiter

Overview:
- Shares one memory bus between the instruction-fetch port and the load/store data port of the rice core.
- Selects one requester per bus request, holds that choice until the bus accepts the request, and tracks outstanding transactions in order.
- Routes each in-order response back to the requester that issued it.
- Sits between the core's IF/EX stages and the external memory bus.

Parameters:
- ADDRESS_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, read/write data width; strobe width = DATA_WIDTH/8
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered bus transactions (>=1)

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_inst_request_valid  input  1  fetch request
- o_inst_request_ready  output  1  fetch request accepted
- i_inst_address  input  ADDRESS_WIDTH  fetch address
- o_inst_response_valid  output  1  fetch response
- i_inst_response_ready  input  1  fetch response consumed
- o_inst_read_data  output  DATA_WIDTH  fetched instruction
- o_inst_error  output  1  fetch bus error
- i_data_request_valid  input  1  load/store request
- o_data_request_ready  output  1  load/store request accepted
- i_data_address  input  ADDRESS_WIDTH  load/store address
- i_data_write  input  1  1 = store, 0 = load
- i_data_write_data  input  DATA_WIDTH  store data
- i_data_strobe  input  DATA_WIDTH/8  byte enables
- o_data_response_valid  output  1  load/store response
- i_data_response_ready  input  1  load/store response consumed
- o_data_read_data  output  DATA_WIDTH  load data
- o_data_error  output  1  load/store bus error
- o_bus_request_valid  output  1  shared bus request
- i_bus_request_ready  input  1  bus accepts request
- o_bus_address, o_bus_write, o_bus_write_data, o_bus_strobe  output  as above  muxed request fields
- i_bus_response_valid  input  1  bus response
- o_bus_response_ready  output  1  response consumed
- i_bus_read_data  input  DATA_WIDTH  response data
- i_bus_error  input  1  response error

Behaviour:
- Handshake rules: a transfer occurs when valid && ready are both high on a rising edge of i_clk. Requesters keep valid and all fields stable until ready.
- Reset values: outstanding count = 0, ID FIFO empty, lock state = UNLOCKED. All valid/ready outputs are 0. Muxed bus fields output 0 when no requester is selected.
- Lock FSM states: UNLOCKED, LOCK_INST, LOCK_DATA.
  - UNLOCKED: select combinationally by arbitration policy among active requests.
  - Selected request not accepted (valid && !i_bus_request_ready): go to LOCK_<selected>. Selection is held regardless of the other requester.
  - LOCK_x: on acceptance, return to UNLOCKED.
- Request forwarding:
  - o_bus_request_valid = selected valid && (count < MAX_OUTSTANDING).
  - o_<selected>_request_ready = i_bus_request_ready && (count < MAX_OUTSTANDING).
  - The non-selected ready is 0.
  - count is the registered value; a response popped in the same cycle does not unblock a request.
- Request latency is zero cycles: combinational path from requester to bus.
- Accept: push the requester ID (0 = inst, 1 = data) into the FIFO (depth MAX_OUTSTANDING) and count += 1.
- Response: the FIFO head selects the destination. o_bus_response_ready = destination's response_ready. Data and error pass through combinationally to both ports; only the head's valid is asserted.
- Response handshake: pop the FIFO and count -= 1.
- Simultaneous accept and response: push and pop together; count unchanged.
- FIFO empty: o_bus_response_ready = 0. i_bus_response_valid while empty is ignored.
- Reset asserted mid-transaction: discards all outstanding state immediately. No responses are forwarded after reset deassertion until new requests are accepted.

Optional Feature:
- RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN defined:
  - A last_grant register (reset = data) updates on each bus request acceptance.
  - When both requests are active in UNLOCKED, the requester other than last_grant wins.
- Not defined: fixed priority, data port over instruction port. No last_grant register.

Test Plan:
- Inst only, address 0x0000_0100, bus ready = 1, response 0x0000_0013 one cycle later -> o_bus_address = 0x100 in the request cycle; o_inst_response_valid = 1 with data 0x13; count returns to 0.
- Both valid, no macro, bus ready = 1 for 3 cycles -> data granted all 3 cycles; inst ready stays 0.
- Both valid, macro defined, bus ready = 1 -> grants alternate inst, data, inst (first grant inst after reset).
- Inst selected, bus ready = 0 for 2 cycles while data rises -> LOCK_INST is held; inst accepted in cycle 3; data granted in cycle 4.
- MAX_OUTSTANDING = 2: accept inst then data with no responses -> third request blocked (bus valid = 0). Responses return in order inst then data and route correctly; i_inst_response_ready = 0 stalls o_bus_response_ready.
- Reset pulse with 2 outstanding, then stray i_bus_response_valid -> no response_valid on either port; o_bus_response_ready = 0.
